ram_capture: RTL and testbench

- Write-side counterpart of the BRAM playback path: samples an 8-bit input bus on a valid strobe and stores it in an inferred single-clock RAM (one SB_RAM40_4K at default size).
- Once the capture finishes, the stored samples are read back through a registered random-access port.
- Sits between board input pins or a sampler and whatever later streams the buffer out.

---
 rtl/ram_capture.sv | 137 +++++++++++++
 tb/tb_ram_capture.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_capture.sv
// rtl/ram_capture.sv - captures valid-strobed samples into an inferred RAM, then serves registered random-access reads.
// Optional trigger qualification (ARMED state, trig_mask/trig_value ports) is built when RAM_CAPTURE_TRIGGER_EN is defined.
module ram_capture #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 9
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              arm,
   input  logic              stop,
   input  logic              din_valid,
   input  logic [DATA_W-1:0] din,
`ifdef RAM_CAPTURE_TRIGGER_EN
   input  logic [DATA_W-1:0] trig_mask,
   input  logic [DATA_W-1:0] trig_value,
`endif
   output logic              busy,
   output logic              done,
   output logic              overflow,
   output logic [ADDR_W:0]   count,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W+1)'(DEPTH - 1);
   localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(DEPTH);

`ifdef RAM_CAPTURE_TRIGGER_EN
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } state_t;
`else
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } state_t;
`endif

   state_t state, state_nxt;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] wr_addr;
   logic              wr_en;
   logic              clr;
   logic              rd_ok;

`ifdef RAM_CAPTURE_TRIGGER_EN
   logic trig_hit;
   assign trig_hit = ((din ^ trig_value) & trig_mask) == '0;
   assign busy     = (state == ARMED) || (state == CAPTURE);
`else
   assign busy     = (state == CAPTURE);
`endif
   assign done     = (state == DONE);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      wr_en     = 1'b0;
      clr       = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (arm) begin
               clr = 1'b1;
`ifdef RAM_CAPTURE_TRIGGER_EN
               state_nxt = ARMED;
`else
               state_nxt = CAPTURE;
`endif
            end
         end
`ifdef RAM_CAPTURE_TRIGGER_EN
         ARMED: begin
            // wr_addr was cleared by arm, so the trigger sample lands at address 0
            if (stop) begin
               state_nxt = DONE;
            end else if (din_valid && trig_hit) begin
               wr_en     = 1'b1;
               state_nxt = CAPTURE;
            end
         end
`endif
         CAPTURE: begin
            if (din_valid && count != CNT_FULL) wr_en = 1'b1;
            if (stop || (din_valid && count == CNT_LAST)) state_nxt = DONE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wr_addr  <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else if (clr) begin
         wr_addr  <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (wr_en) begin
            wr_addr <= wr_addr + 1'b1;
            count   <= count + 1'b1;
         end
         if (state == DONE && din_valid && count == CNT_FULL) overflow <= 1'b1;
      end
   end

   // RAM array has no reset so it maps onto block RAM and survives RST
   always_ff @(posedge CLK) begin
      if (wr_en) mem[wr_addr] <= din;
   end

   assign rd_ok = rd_en && (state == IDLE || state == DONE);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= rd_ok;
         if (rd_ok) rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: tb/tb_ram_capture.sv
// tb/tb_ram_capture.sv - directed self-checking bench for ram_capture.
// Trigger scenario is included when RAM_CAPTURE_TRIGGER_EN is defined.
module tb_ram_capture;

   logic       CLK = 1'b0;
   logic       RST;
   logic       arm, stop, din_valid, rd_en;
   logic [7:0] din;
   logic [8:0] rd_addr;
   logic       busy, done, overflow, rd_valid;
   logic [9:0] count;
   logic [7:0] rd_data;
`ifdef RAM_CAPTURE_TRIGGER_EN
   logic [7:0] trig_mask, trig_value;
`endif

   int checks   = 0;
   int failures = 0;

   ram_capture dut (
      .CLK(CLK), .RST(RST), .arm(arm), .stop(stop),
      .din_valid(din_valid), .din(din),
`ifdef RAM_CAPTURE_TRIGGER_EN
      .trig_mask(trig_mask), .trig_value(trig_value),
`endif
      .busy(busy), .done(done), .overflow(overflow), .count(count),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic pulse_arm();
      arm = 1'b1;
      tick();
      arm = 1'b0;
   endtask

   task automatic do_read(input logic [8:0] a);
      rd_en   = 1'b1;
      rd_addr = a;
      tick();
      rd_en   = 1'b0;
   endtask

   task automatic test_reset();
      checks++;
      if ({busy, done, overflow, rd_valid} !== 4'b0000 || count !== 10'd0 || rd_data !== 8'h00) begin
         failures++;
         $display("FAIL reset: busy=%b done=%b ovf=%b rdv=%b count=%0d rd_data=%h, required all zero",
                  busy, done, overflow, rd_valid, count, rd_data);
      end
   endtask

   task automatic test_full_capture();
      pulse_arm();
      checks++;
      if (busy !== 1'b1 || count !== 10'd0) begin
         failures++;
         $display("FAIL arm_start: busy=%b count=%0d, required busy=1 count=0", busy, count);
      end
      for (int i = 0; i < 512; i++) begin
         din_valid = 1'b1;
         din       = 8'(i);
         tick();
         if (i == 510) begin
            checks++;
            if (done !== 1'b0 || count !== 10'd511) begin
               failures++;
               $display("FAIL pre_full: done=%b count=%0d, required done=0 count=511", done, count);
            end
         end
      end
      din_valid = 1'b0;
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || count !== 10'd512) begin
         failures++;
         $display("FAIL full_done: done=%b busy=%b count=%0d, required done=1 busy=0 count=512", done, busy, count);
      end
      do_read(9'd0);
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== 8'h00) begin
         failures++;
         $display("FAIL read0: rd_valid=%b rd_data=%h, required 1 / 00", rd_valid, rd_data);
      end
      tick();
      checks++;
      if (rd_valid !== 1'b0) begin
         failures++;
         $display("FAIL rd_valid_drop: rd_valid=%b, required 0", rd_valid);
      end
      do_read(9'd255);
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== 8'hFF) begin
         failures++;
         $display("FAIL read255: rd_valid=%b rd_data=%h, required 1 / ff", rd_valid, rd_data);
      end
      do_read(9'd511);
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== 8'hFF) begin
         failures++;
         $display("FAIL read511: rd_valid=%b rd_data=%h, required 1 / ff", rd_valid, rd_data);
      end
   endtask

   task automatic test_overflow();
      din_valid = 1'b1;
      din       = 8'h77;
      repeat (3) tick();
      din_valid = 1'b0;
      checks++;
      if (overflow !== 1'b1 || count !== 10'd512) begin
         failures++;
         $display("FAIL overflow_set: overflow=%b count=%0d, required 1 / 512", overflow, count);
      end
      do_read(9'd0);
      checks++;
      if (rd_data !== 8'h00) begin
         failures++;
         $display("FAIL overflow_nowrite: rd_data=%h, required 00", rd_data);
      end
      pulse_arm();
      checks++;
      if (overflow !== 1'b0 || count !== 10'd0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL rearm: overflow=%b count=%0d busy=%b, required 0 / 0 / 1", overflow, count, busy);
      end
      stop = 1'b1;
      tick();
      stop = 1'b0;
      checks++;
      if (done !== 1'b1 || count !== 10'd0) begin
         failures++;
         $display("FAIL stop_empty: done=%b count=%0d, required 1 / 0", done, count);
      end
      din_valid = 1'b1;
      tick();
      din_valid = 1'b0;
      checks++;
      if (overflow !== 1'b0 || count !== 10'd0) begin
         failures++;
         $display("FAIL done_after_stop_ignore: overflow=%b count=%0d, required 0 / 0", overflow, count);
      end
   endtask

   task automatic test_stop();
      pulse_arm();
      for (int i = 0; i < 10; i++) begin
         din_valid = 1'b1;
         din       = 8'hA0 + 8'(i);
         stop      = (i == 9);
         tick();
      end
      din_valid = 1'b0;
      stop      = 1'b0;
      checks++;
      if (count !== 10'd10 || done !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL stop_capture: count=%0d done=%b busy=%b, required 10 / 1 / 0", count, done, busy);
      end
      stop = 1'b1;
      tick();
      stop = 1'b0;
      checks++;
      if (count !== 10'd10 || done !== 1'b1) begin
         failures++;
         $display("FAIL stop_in_done: count=%0d done=%b, required 10 / 1", count, done);
      end
      do_read(9'd9);
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== 8'hA9) begin
         failures++;
         $display("FAIL read9: rd_valid=%b rd_data=%h, required 1 / a9", rd_valid, rd_data);
      end
   endtask

   task automatic test_reset_mid_capture();
      pulse_arm();
      for (int i = 0; i < 100; i++) begin
         din_valid = 1'b1;
         din       = 8'(i) ^ 8'h5A;
         arm       = (i == 50);
         tick();
      end
      din_valid = 1'b0;
      arm       = 1'b0;
      checks++;
      if (count !== 10'd100 || busy !== 1'b1) begin
         failures++;
         $display("FAIL arm_while_busy: count=%0d busy=%b, required 100 / 1", count, busy);
      end
      do_read(9'd50);
      checks++;
      if (rd_valid !== 1'b0 || rd_data !== 8'hA9) begin
         failures++;
         $display("FAIL read_in_capture: rd_valid=%b rd_data=%h, required 0 / a9", rd_valid, rd_data);
      end
      RST = 1'b1;
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || count !== 10'd0) begin
         failures++;
         $display("FAIL async_reset: busy=%b done=%b count=%0d, required 0 / 0 / 0", busy, done, count);
      end
      tick();
      RST = 1'b0;
      tick();
      do_read(9'd50);
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== 8'h68) begin
         failures++;
         $display("FAIL ram_survives_reset: rd_valid=%b rd_data=%h, required 1 / 68", rd_valid, rd_data);
      end
   endtask

   task automatic test_read_and_arm();
      pulse_arm();
      stop = 1'b1;
      tick();
      stop    = 1'b0;
      rd_en   = 1'b1;
      rd_addr = 9'd3;
      arm     = 1'b1;
      tick();
      rd_en = 1'b0;
      arm   = 1'b0;
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== 8'h59 || busy !== 1'b1) begin
         failures++;
         $display("FAIL read_with_arm: rd_valid=%b rd_data=%h busy=%b, required 1 / 59 / 1", rd_valid, rd_data, busy);
      end
      stop = 1'b1;
      tick();
      stop = 1'b0;
   endtask

`ifdef RAM_CAPTURE_TRIGGER_EN
   task automatic test_trigger();
      logic [7:0] stream [4];
      stream[0] = 8'h10; stream[1] = 8'h2F; stream[2] = 8'h5A; stream[3] = 8'h11;
      trig_mask  = 8'hF0;
      trig_value = 8'h50;
      pulse_arm();
      for (int i = 0; i < 4; i++) begin
         din_valid = 1'b1;
         din       = stream[i];
         tick();
      end
      din_valid = 1'b0;
      stop = 1'b1;
      tick();
      stop = 1'b0;
      checks++;
      if (count !== 10'd2 || done !== 1'b1) begin
         failures++;
         $display("FAIL trig_count: count=%0d done=%b, required 2 / 1", count, done);
      end
      do_read(9'd0);
      checks++;
      if (rd_data !== 8'h5A) begin
         failures++;
         $display("FAIL trig_addr0: rd_data=%h, required 5a", rd_data);
      end
      do_read(9'd1);
      checks++;
      if (rd_data !== 8'h11) begin
         failures++;
         $display("FAIL trig_addr1: rd_data=%h, required 11", rd_data);
      end
   endtask
`endif

   initial begin
      RST = 1'b1; arm = 1'b0; stop = 1'b0; din_valid = 1'b0; din = 8'h00;
      rd_en = 1'b0; rd_addr = 9'd0;
`ifdef RAM_CAPTURE_TRIGGER_EN
      trig_mask = 8'h00; trig_value = 8'h00;
`endif
      tick();
      tick();
      RST = 1'b0;
      tick();
      test_reset();
      test_full_capture();
      test_overflow();
      test_stop();
      test_reset_mid_capture();
      test_read_and_arm();
`ifdef RAM_CAPTURE_TRIGGER_EN
      test_trigger();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
